// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception sequencer: CP0 register numbers,
// ExcCode values, the redirect vector and the sequencer state encoding.
package exc_ctrl_pkg;

  localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  localparam logic [31:0] STATUS_EXL = 32'h0000_0002;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_EPC,
    ST_WR_STATUS,
    ST_ERET_WR,
    ST_VECTOR
  } state_t;

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// Parameterised-width two-flop synchronizer with synchronous active-low reset.
// Used for the external interrupt lines when EXC_INT_SYNC_EN is defined.
module int_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta <= '0;
      q    <= '0;
    end else begin
      // NOTE: non-blocking assignments make meta and q update together at the
      // edge, so q sees the old meta and the chain is really two flops deep.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: records EPC, sets/clears Status.EXL through
// CP0's write port, then flushes with a redirect PC. Build option:
// EXC_INT_SYNC_EN adds a two-flop synchronizer on ext_int_i.
module exc_ctrl
  import exc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        instr_done_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_next_i,
  input  logic        adel_i,
  input  logic        ri_i,
  input  logic        ov_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        eret_i,
  input  logic [5:0]  ext_int_i,
  input  logic        timer_int_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic [5:0]  int_o,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_wdata_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [4:0]  exc_code_o,
  output logic        busy_o
);

  logic [5:0] ext_int;

`ifdef EXC_INT_SYNC_EN
  int_sync #(.W(6)) u_int_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (ext_int_i),
    .q      (ext_int)
  );
`else
  assign ext_int = ext_int_i;
`endif

  // The timer interrupt shares hardware line 5 and is never synchronized.
  assign int_o = {ext_int[5] | timer_int_i, ext_int[4:0]};

  logic        int_pend;
  logic        exc_hit;
  logic [4:0]  exc_code_c;
  logic [31:0] exc_epc_c;

  assign int_pend = (|(cause_i[15:10] & status_i[15:10])) & status_i[0] & ~status_i[1];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    exc_hit    = 1'b1;
    exc_code_c = EXC_INT;
    exc_epc_c  = pc_i;
    if (int_pend) begin
      exc_epc_c = pc_next_i;
    end else if (adel_i) begin
      exc_code_c = EXC_ADEL;
    end else if (ri_i) begin
      exc_code_c = EXC_RI;
    end else if (ov_i) begin
      exc_code_c = EXC_OV;
    end else if (syscall_i) begin
      exc_code_c = EXC_SYS;
    end else if (break_i) begin
      exc_code_c = EXC_BP;
    end else begin
      exc_hit = 1'b0;
    end
  end

  state_t      state;
  logic [31:0] epc_q;
  logic [4:0]  code_q;
  logic        eret_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      epc_q       <= '0;
      code_q      <= '0;
      eret_q      <= 1'b0;
      cp0_we_o    <= 1'b0;
      cp0_waddr_o <= '0;
      cp0_wdata_o <= '0;
      flush_o     <= 1'b0;
      new_pc_o    <= '0;
      exc_code_o  <= '0;
      busy_o      <= 1'b0;
    end else begin
      cp0_we_o    <= 1'b0;
      cp0_waddr_o <= '0;
      cp0_wdata_o <= '0;
      flush_o     <= 1'b0;
      new_pc_o    <= '0;
      unique case (state)
        ST_IDLE: begin
          if (instr_done_i && exc_hit) begin
            epc_q    <= exc_epc_c;
            code_q   <= exc_code_c;
            eret_q   <= 1'b0;
            busy_o   <= 1'b1;
            cp0_we_o <= 1'b1;
            // A nested exception (EXL already set) must not clobber EPC.
            if (status_i[1]) begin
              state       <= ST_WR_STATUS;
              cp0_waddr_o <= CP0_REG_STATUS;
              cp0_wdata_o <= status_i | STATUS_EXL;
            end else begin
              state       <= ST_WR_EPC;
              cp0_waddr_o <= CP0_REG_EPC;
              cp0_wdata_o <= exc_epc_c;
            end
          end else if (instr_done_i && eret_i) begin
            epc_q       <= epc_i;
            eret_q      <= 1'b1;
            busy_o      <= 1'b1;
            state       <= ST_ERET_WR;
            cp0_we_o    <= 1'b1;
            cp0_waddr_o <= CP0_REG_STATUS;
            cp0_wdata_o <= status_i & ~STATUS_EXL;
          end
        end
        ST_WR_EPC: begin
          state       <= ST_WR_STATUS;
          cp0_we_o    <= 1'b1;
          cp0_waddr_o <= CP0_REG_STATUS;
          cp0_wdata_o <= status_i | STATUS_EXL;
        end
        ST_WR_STATUS, ST_ERET_WR: begin
          state    <= ST_VECTOR;
          flush_o  <= 1'b1;
          new_pc_o <= eret_q ? epc_q : EXC_VECTOR;
          if (!eret_q) exc_code_o <= code_q;
        end
        ST_VECTOR: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed cases plus randomized events
// compared cycle by cycle against a per-event expected write/flush schedule.
module tb_exc_ctrl;
  import exc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        instr_done_i;
  logic [31:0] pc_i, pc_next_i;
  logic        adel_i, ri_i, ov_i, syscall_i, break_i, eret_i;
  logic [5:0]  ext_int_i;
  logic        timer_int_i;
  logic [31:0] status_i, cause_i, epc_i;
  logic [5:0]  int_o;
  logic        cp0_we_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_wdata_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [4:0]  exc_code_o;
  logic        busy_o;

  exc_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .instr_done_i (instr_done_i),
    .pc_i         (pc_i),
    .pc_next_i    (pc_next_i),
    .adel_i       (adel_i),
    .ri_i         (ri_i),
    .ov_i         (ov_i),
    .syscall_i    (syscall_i),
    .break_i      (break_i),
    .eret_i       (eret_i),
    .ext_int_i    (ext_int_i),
    .timer_int_i  (timer_int_i),
    .status_i     (status_i),
    .cause_i      (cause_i),
    .epc_i        (epc_i),
    .int_o        (int_o),
    .cp0_we_o     (cp0_we_o),
    .cp0_waddr_o  (cp0_waddr_o),
    .cp0_wdata_o  (cp0_wdata_o),
    .flush_o      (flush_o),
    .new_pc_o     (new_pc_o),
    .exc_code_o   (exc_code_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    bit          flush;
    logic [31:0] npc;
  } cyc_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [4:0]  exp_code = '0;
  cyc_t        seq[$];
  cyc_t        idle_c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_cycle(input string tag, input cyc_t c, input bit busy_exp);
    check({tag, ".we"}, {31'd0, cp0_we_o}, {31'd0, c.we});
    if (c.we) begin
      check({tag, ".waddr"}, {27'd0, cp0_waddr_o}, {27'd0, c.waddr});
      check({tag, ".wdata"}, cp0_wdata_o, c.wdata);
    end
    check({tag, ".flush"}, {31'd0, flush_o}, {31'd0, c.flush});
    if (c.flush) check({tag, ".new_pc"}, new_pc_o, c.npc);
    check({tag, ".busy"}, {31'd0, busy_o}, {31'd0, busy_exp});
    check({tag, ".code"}, {27'd0, exc_code_o}, {27'd0, exp_code});
`ifndef EXC_INT_SYNC_EN
    check({tag, ".int"}, {26'd0, int_o}, {26'd0, ext_int_i[5] | timer_int_i, ext_int_i[4:0]});
`endif
  endtask

  task automatic clr_flags();
    adel_i = 0; ri_i = 0; ov_i = 0; syscall_i = 0; break_i = 0; eret_i = 0;
  endtask

  // Reference: from the inputs present at the strobe, list what each busy
  // cycle must show, then expect a quiet idle cycle.
  task automatic run_event(input string tag, input bit busy_strobe);
    logic       int_pend;
    bit         is_exc;
    logic [4:0] code;
    logic [31:0] epc_v;
    seq.delete();
    int_pend = (|(cause_i[15:10] & status_i[15:10])) && status_i[0] && !status_i[1];
    is_exc = 1;
    code = 5'h00;
    epc_v = int_pend ? pc_next_i : pc_i;
    if (int_pend)       code = 5'h00;
    else if (adel_i)    code = 5'h04;
    else if (ri_i)      code = 5'h0A;
    else if (ov_i)      code = 5'h0C;
    else if (syscall_i) code = 5'h08;
    else if (break_i)   code = 5'h09;
    else                is_exc = 0;
    if (is_exc) begin
      if (!status_i[1]) seq.push_back(cyc_t'{1'b1, 5'd14, epc_v, 1'b0, 32'd0});
      seq.push_back(cyc_t'{1'b1, 5'd12, status_i | 32'h2, 1'b0, 32'd0});
      seq.push_back(cyc_t'{1'b0, 5'd0, 32'd0, 1'b1, 32'h8000_0180});
    end else if (eret_i) begin
      seq.push_back(cyc_t'{1'b1, 5'd12, status_i & ~32'h2, 1'b0, 32'd0});
      seq.push_back(cyc_t'{1'b0, 5'd0, 32'd0, 1'b1, epc_i});
    end
    instr_done_i = 1;
    step();
    instr_done_i = (seq.size() != 0) && busy_strobe;
    foreach (seq[i]) begin
      if (seq[i].flush && is_exc) exp_code = code;
      check_cycle($sformatf("%s.c%0d", tag, i), seq[i], 1'b1);
      step();
    end
    instr_done_i = 0;
    check_cycle({tag, ".idle"}, idle_c, 1'b0);
  endtask

  initial begin
    idle_c = cyc_t'{1'b0, 5'd0, 32'd0, 1'b0, 32'd0};
    resetn = 0; instr_done_i = 0; pc_i = 0; pc_next_i = 0;
    clr_flags();
    ext_int_i = 0; timer_int_i = 0; status_i = 0; cause_i = 0; epc_i = 0;
    @(negedge clk);
    step();
    step();
    check("rst.int", {26'd0, int_o}, 32'd0);
    check("rst.newpc", new_pc_o, 32'd0);
    check("rst.wdata", cp0_wdata_o, 32'd0);
    check("rst.waddr", {27'd0, cp0_waddr_o}, 32'd0);
    check_cycle("rst", idle_c, 1'b0);
    resetn = 1;
    step();
    check_cycle("idle0", idle_c, 1'b0);

    // syscall with EXL clear
    status_i = 32'h1000_0000; pc_i = 32'h0040_0010; pc_next_i = 32'h0040_0014;
    syscall_i = 1;
    run_event("sys", 1'b0);
    clr_flags();

    // enabled interrupt on IM2 / ext line 0
    status_i = 32'h1000_0401; cause_i = 32'h0000_0400; ext_int_i = 6'h01;
    pc_i = 32'h0040_0020; pc_next_i = 32'h0040_0024;
    run_event("int", 1'b0);
    // same with IE=0: no event
    status_i = 32'h1000_0400;
    run_event("int_ie0", 1'b0);
    cause_i = 0; ext_int_i = 0;

    // multiple exceptions at once: AdEL wins; strobes while busy ignored
    status_i = 32'h1000_0000; pc_i = 32'h0040_0030;
    adel_i = 1; ri_i = 1; ov_i = 1;
    run_event("multi", 1'b1);
    clr_flags();

    // nested break with EXL set
    status_i = 32'h1000_0003; pc_i = 32'h0040_0040; break_i = 1;
    run_event("bp_exl", 1'b0);
    clr_flags();

    // ERET
    status_i = 32'h1000_0002; epc_i = 32'h0040_0100; eret_i = 1;
    run_event("eret", 1'b1);
    clr_flags();

    // timer interrupt on hardware line 5
    timer_int_i = 1; ext_int_i = 6'h0A;
    step();
    check_cycle("timer", idle_c, 1'b0);
    timer_int_i = 0; ext_int_i = 0;

    // reset during the WR_STATUS cycle abandons the sequence
    status_i = 32'h1000_0000; pc_i = 32'h0040_0050; syscall_i = 1;
    instr_done_i = 1;
    step();
    instr_done_i = 0;
    clr_flags();
    check_cycle("mid.epc", cyc_t'{1'b1, 5'd14, 32'h0040_0050, 1'b0, 32'd0}, 1'b1);
    step();
    check_cycle("mid.st", cyc_t'{1'b1, 5'd12, 32'h1000_0002, 1'b0, 32'd0}, 1'b1);
    resetn = 0;
    step();
    exp_code = 0;
    check_cycle("mid.rst", idle_c, 1'b0);
    check("mid.newpc", new_pc_o, 32'd0);
    resetn = 1;
    step();
    check_cycle("mid.after", idle_c, 1'b0);

    // randomized events
    for (int n = 0; n < 60; n++) begin
      status_i    = $urandom;
      cause_i     = $urandom;
      pc_i        = $urandom & 32'hFFFF_FFFC;
      pc_next_i   = pc_i + 32'd4;
      epc_i       = $urandom & 32'hFFFF_FFFC;
      ext_int_i   = 6'($urandom);
      timer_int_i = 1'($urandom);
      adel_i      = ($urandom_range(0, 5) == 0);
      ri_i        = ($urandom_range(0, 5) == 0);
      ov_i        = ($urandom_range(0, 5) == 0);
      syscall_i   = ($urandom_range(0, 5) == 0);
      break_i     = ($urandom_range(0, 5) == 0);
      eret_i      = ($urandom_range(0, 3) == 0);
      run_event($sformatf("rnd%0d", n), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/interrupt sequencer for the multi-cycle MIPS core, sitting between the instruction-boundary control FSM and the CP0 register file. It samples exception flags and pending interrupts at each instruction boundary and drives CP0's single write port to record EPC and set or clear Status.EXL. It then issues a one-cycle flush with a redirect PC and supplies CP0's `int_i` hardware-interrupt lines.

## Interface
- EXC_VECTOR, 32'h8000_0180: redirect PC for all exceptions and interrupts.
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- instr_done_i  in  1  one-cycle strobe at the instruction boundary; flags below valid only then
- pc_i  in  32  PC of the completing instruction
- pc_next_i  in  32  PC of the next instruction
- adel_i, ri_i, ov_i, syscall_i, break_i, eret_i  in  1 each  exception/ERET flags
- ext_int_i  in  6  raw external interrupt lines
- timer_int_i  in  1  CP0 timer interrupt
- status_i, cause_i, epc_i  in  32 each  current CP0 Status/Cause/EPC
- int_o  out  6  to CP0 `int_i`
- cp0_we_o  out  1;  cp0_waddr_o  out  5;  cp0_wdata_o  out  32  CP0 write port
- flush_o  out  1  one-cycle redirect strobe
- new_pc_o  out  32  redirect target, valid with flush_o
- exc_code_o  out  5  ExcCode of the last taken exception
- busy_o  out  1  high in any non-IDLE state; sequencer must stall

## Operation
- int_o = {ext_int[5] | timer_int_i, ext_int[4:0]}. ext_int is the raw or synchronized `ext_int_i`; see Configuration.
- int_pend = |(cause_i[15:10] & status_i[15:10]) & status_i[0] & ~status_i[1].
- Priority on instr_done_i in IDLE: int_pend > adel > ri > ov > syscall > break > eret.
- ExcCodes: Int 0x00, AdEL 0x04, Sys 0x08, Bp 0x09, RI 0x0A, Ov 0x0C.
- Latched at sample time:
  - epc_q = pc_next_i for an interrupt, pc_i otherwise; epc_i for ERET.
  - code_q.
  - exl_q = status_i[1].
- States:
  - IDLE: no event → stay. Exception or interrupt → WR_EPC, or WR_STATUS if exl_q=1 (EPC not overwritten). eret → ERET_WR.
  - WR_EPC: we=1, waddr=14, wdata=epc_q → WR_STATUS.
  - WR_STATUS: we=1, waddr=12, wdata=status_i | 32'h2 → VECTOR.
  - ERET_WR: we=1, waddr=12, wdata=status_i & ~32'h2 → VECTOR.
  - VECTOR: flush_o=1. new_pc_o = EXC_VECTOR, or epc_q for ERET. exc_code_o ← code_q (not for ERET) → IDLE.
- instr_done_i while busy_o=1: ignored.
- No event: outputs stay inactive.

## Timing
- Reset (synchronous) → IDLE next edge. All outputs 0: int_o, cp0_we_o, cp0_waddr_o, cp0_wdata_o, flush_o, new_pc_o, exc_code_o, busy_o.
- Reset mid-sequence: abandon it; no further writes or flush.
- All outputs registered.
- Exception latency, strobe at edge N:
  - WR_EPC write at N+1.
  - Status write at N+2.
  - flush_o at N+3.
  - With EXL=1: Status write at N+1, flush at N+2.
- ERET latency: Status write at N+1, flush at N+2.
- cp0_we_o is never high in IDLE or VECTOR.
- busy_o is high from N+1 through the VECTOR cycle.

## Configuration
- EXC_INT_SYNC_EN defined: ext_int_i passes through a two-flop synchronizer (reset 0) before int_o, adding 2 cycles latency.
- EXC_INT_SYNC_EN undefined: ext_int_i feeds int_o combinationally.
- timer_int_i is never synchronized.

## Structure
- Shared define file holds:
  - CP0_REG_STATUS(12), CP0_REG_CAUSE(13), CP0_REG_EPC(14).
  - The ExcCode constants.
  - The state encoding.
- Sub-module: `int_sync`, a parameterised-width two-flop synchronizer, instantiated only under EXC_INT_SYNC_EN.

## Test plan
- Status=0x1000_0000, syscall_i with pc_i=0x0040_0010 → EPC write 0x0040_0010, Status write 0x1000_0002, flush with new_pc=0x8000_0180, exc_code=0x08.
- Status=0x1000_0401, ext_int_i[0]=1 so Cause[10]=1, strobe with pc_next_i=0x0040_0024 → EPC=0x0040_0024, ExcCode 0x00. Repeat with Status IE=0 → no flush.
- adel_i, ri_i and ov_i together → single sequence, exc_code=0x04.
- Status EXL=1, break_i → no EPC write, Status write at N+1, flush at N+2, exc_code=0x09.
- eret_i with epc_i=0x0040_0100, Status=0x1000_0002 → Status write 0x1000_0000, flush with new_pc=0x0040_0100.
- resetn low at the WR_STATUS cycle → no flush; all outputs 0 next cycle. Strobe during busy ignored.
